cache_bus_arbiter_multicore: RTL and testbench

Parametrised arbiter for the shared lv1–lv2 bus in an N-core MESI cache hierarchy. It replaces the fixed four-core req/gnt handling at the cache top level. It grants one processor-side owner at a time using round-robin. While that owner holds the bus, it nests snoop grants from other cores and lv2 response grants under the owner. A hold-time watchdog flags stuck transactions.

---
 rtl/cache_bus_arb_pkg.sv | 15 +
 rtl/cache_rr_picker.sv | 36 +++
 rtl/cache_bus_arbiter_multicore.sv | 174 +++++++++++++++++
 tb/tb_cache_bus_arbiter_multicore.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_arb_pkg.sv
// Shared types and defaults for the lv1-lv2 bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package cache_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROC,
    ST_SNOOP,
    ST_LV2
  } arb_state_e;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_MAX_HOLD  = 64;

endpackage

// File: rtl/cache_rr_picker.sv
// Round-robin picker: first unmasked requester at or after ptr_i,
// wrapping modulo NUM_CORES (any core count, not only powers of two).
module cache_rr_picker
  import cache_bus_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ID_WID    = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [ID_WID-1:0]    ptr_i,
  input  logic [NUM_CORES-1:0] excl_i,
  output logic                 valid_o,
  output logic [ID_WID-1:0]    idx_o
);

  logic [NUM_CORES-1:0] cand;
  int                   j;

  assign cand = req_i & ~excl_i;

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (cand[ID_WID'(j)]) begin
        valid_o = 1'b1;
        idx_o   = ID_WID'(j);
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter_multicore.sv
// Shared lv1-lv2 bus arbiter: round-robin processor owner with nested
// snoop / lv2 grants under it and a hold-time watchdog.
module cache_bus_arbiter_multicore
  import cache_bus_arb_pkg::*;
#(
  parameter int NUM_CORES    = DEF_NUM_CORES,
  parameter int CORE_ID_WID  = $clog2(NUM_CORES),
  parameter int MAX_HOLD     = DEF_MAX_HOLD,
  parameter int HOLD_CNT_WID = $clog2(MAX_HOLD + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
  input  logic                   bus_lv1_lv2_req_lv2,
  output logic                   bus_lv1_lv2_gnt_lv2,
  output logic [CORE_ID_WID-1:0] bus_owner_id,
  output logic                   bus_busy,
  output logic                   bus_timeout
);

  localparam logic [HOLD_CNT_WID-1:0] HOLD_ONE =
    HOLD_CNT_WID'(1);
  localparam logic [HOLD_CNT_WID-1:0] HOLD_MAX =
    HOLD_CNT_WID'(MAX_HOLD);
  localparam logic [HOLD_CNT_WID-1:0] HOLD_PRE =
    HOLD_CNT_WID'(MAX_HOLD - 1);
  localparam logic TMO_AT_START = (MAX_HOLD == 1);

  arb_state_e               state_q;
  logic [NUM_CORES-1:0]     gnt_proc_q;
  logic [NUM_CORES-1:0]     gnt_snoop_q;
  logic                     gnt_lv2_q;
  logic                     busy_q;
  logic                     tmo_q;
  logic [CORE_ID_WID-1:0]   owner_q;
  logic [CORE_ID_WID-1:0]   snp_win_q;
  logic [CORE_ID_WID-1:0]   proc_ptr_q;
  logic [CORE_ID_WID-1:0]   snp_ptr_q;
  logic [HOLD_CNT_WID-1:0]  hold_q;

  logic                     proc_vld;
  logic                     snp_vld;
  logic [CORE_ID_WID-1:0]   proc_idx;
  logic [CORE_ID_WID-1:0]   snp_idx;
  logic                     own_req;
  logic                     win_req;

  function automatic logic [CORE_ID_WID-1:0] inc_id(
    input logic [CORE_ID_WID-1:0] x
  );
    if (int'(x) >= NUM_CORES - 1) return '0;
    return x + 1'b1;
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(
    input logic [CORE_ID_WID-1:0] i
  );
    return NUM_CORES'(1) << i;
  endfunction

  assign own_req = bus_lv1_lv2_req_proc[owner_q];
  assign win_req = bus_lv1_lv2_req_snoop[snp_win_q];

  cache_rr_picker #(
    .NUM_CORES (NUM_CORES),
    .ID_WID    (CORE_ID_WID)
  ) u_proc_pick (
    .req_i   (bus_lv1_lv2_req_proc),
    .ptr_i   (proc_ptr_q),
    .excl_i  ({NUM_CORES{1'b0}}),
    .valid_o (proc_vld),
    .idx_o   (proc_idx)
  );

  // The owner's own snoop line is masked by its proc grant.
  cache_rr_picker #(
    .NUM_CORES (NUM_CORES),
    .ID_WID    (CORE_ID_WID)
  ) u_snp_pick (
    .req_i   (bus_lv1_lv2_req_snoop),
    .ptr_i   (snp_ptr_q),
    .excl_i  (gnt_proc_q),
    .valid_o (snp_vld),
    .idx_o   (snp_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      gnt_lv2_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      owner_q     <= '0;
      snp_win_q   <= '0;
      proc_ptr_q  <= '0;
      snp_ptr_q   <= '0;
      hold_q      <= '0;
    end else begin
      tmo_q <= 1'b0;
      if (busy_q) begin
        if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_ONE;
        tmo_q <= (hold_q == HOLD_PRE);
      end
      // Any grant change below restarts the watchdog.
      unique case (state_q)
        ST_IDLE: begin
          if (proc_vld) begin
            gnt_proc_q <= onehot(proc_idx);
            owner_q    <= proc_idx;
            busy_q     <= 1'b1;
            hold_q     <= HOLD_ONE;
            tmo_q      <= TMO_AT_START;
            state_q    <= ST_PROC;
          end
        end
        ST_PROC: begin
          if (!own_req) begin
            gnt_proc_q <= '0;
            busy_q     <= 1'b0;
            proc_ptr_q <= inc_id(owner_q);
            hold_q     <= '0;
            tmo_q      <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (snp_vld) begin
            gnt_snoop_q <= onehot(snp_idx);
            snp_win_q   <= snp_idx;
            hold_q      <= HOLD_ONE;
            tmo_q       <= TMO_AT_START;
            state_q     <= ST_SNOOP;
          end else if (bus_lv1_lv2_req_lv2) begin
            gnt_lv2_q <= 1'b1;
            hold_q    <= HOLD_ONE;
            tmo_q     <= TMO_AT_START;
            state_q   <= ST_LV2;
          end
        end
        ST_SNOOP, ST_LV2: begin
          if ((state_q == ST_SNOOP && !win_req) ||
              (state_q == ST_LV2 && !bus_lv1_lv2_req_lv2)) begin
            gnt_snoop_q <= '0;
            gnt_lv2_q   <= 1'b0;
            if (state_q == ST_SNOOP) snp_ptr_q <= inc_id(snp_win_q);
            if (own_req) begin
              hold_q  <= HOLD_ONE;
              tmo_q   <= TMO_AT_START;
              state_q <= ST_PROC;
            end else begin
              gnt_proc_q <= '0;
              busy_q     <= 1'b0;
              proc_ptr_q <= inc_id(owner_q);
              hold_q     <= '0;
              tmo_q      <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
  assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
  assign bus_lv1_lv2_gnt_lv2   = gnt_lv2_q;
  assign bus_owner_id          = owner_q;
  assign bus_busy              = busy_q;
  assign bus_timeout           = tmo_q;

endmodule

// File: tb/tb_cache_bus_arbiter_multicore.sv
// Bench for cache_bus_arbiter_multicore: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cache_bus_arbiter_multicore;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MAXH = 8;
  localparam int HCW  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_proc, req_snoop, gnt_proc, gnt_snoop;
  logic           req_lv2, gnt_lv2, busy, tmo;
  logic [IDW-1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  cache_bus_arbiter_multicore #(
    .NUM_CORES    (N),
    .CORE_ID_WID  (IDW),
    .MAX_HOLD     (MAXH),
    .HOLD_CNT_WID (HCW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus_lv1_lv2_req_proc  (req_proc),
    .bus_lv1_lv2_gnt_proc  (gnt_proc),
    .bus_lv1_lv2_req_snoop (req_snoop),
    .bus_lv1_lv2_gnt_snoop (gnt_snoop),
    .bus_lv1_lv2_req_lv2   (req_lv2),
    .bus_lv1_lv2_gnt_lv2   (gnt_lv2),
    .bus_owner_id          (owner),
    .bus_busy              (busy),
    .bus_timeout           (tmo)
  );

  // own<0: bus free; nest 0 none, 1 snoop (nwin), 2 lv2.
  typedef struct packed {
    int own;
    int last;
    int nest;
    int nwin;
    int pptr;
    int sptr;
    int hold;
    bit tmo;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.own = -1; r.last = 0; r.nest = 0; r.nwin = 0;
    r.pptr = 0; r.sptr = 0; r.hold = 0; r.tmo = 1'b0;
    return r;
  endfunction

  function automatic bit bitat(logic [N-1:0] v, int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic mdl_t mdl_next(mdl_t s, logic [N-1:0] rp,
                                    logic [N-1:0] rs, logic rl);
    mdl_t n;
    bit   chg;
    int   c;
    n = s;
    chg = 1'b0;
    if (s.own < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (s.pptr + k) % N;
        if (!chg && bitat(rp, c)) begin
          n.own = c; n.last = c; chg = 1'b1;
        end
      end
    end else if (s.nest == 0) begin
      if (!bitat(rp, s.own)) begin
        n.own = -1; n.pptr = (s.own + 1) % N; chg = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (s.sptr + k) % N;
          if (!chg && c != s.own && bitat(rs, c)) begin
            n.nest = 1; n.nwin = c; chg = 1'b1;
          end
        end
        if (!chg && rl) begin
          n.nest = 2; chg = 1'b1;
        end
      end
    end else if ((s.nest == 1 && !bitat(rs, s.nwin)) ||
                 (s.nest == 2 && !rl)) begin
      if (s.nest == 1) n.sptr = (s.nwin + 1) % N;
      n.nest = 0;
      chg = 1'b1;
      if (!bitat(rp, s.own)) begin
        n.own = -1; n.pptr = (s.own + 1) % N;
      end
    end
    if (chg) n.hold = (n.own >= 0) ? 1 : 0;
    else if (n.own >= 0 && n.hold < MAXH) n.hold = n.hold + 1;
    n.tmo = (n.own >= 0) && (n.hold == MAXH) &&
            (chg || s.hold != MAXH);
    return n;
  endfunction

  function automatic logic [N-1:0] exp_gp(mdl_t s);
    return (s.own >= 0) ? (N'(1) << s.own) : '0;
  endfunction

  function automatic logic [N-1:0] exp_gs(mdl_t s);
    return (s.nest == 1) ? (N'(1) << s.nwin) : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_rst();
    else        m <= mdl_next(m, req_proc, req_snoop, req_lv2);
  end

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("gnt_proc", 32'(gnt_proc), 32'(exp_gp(m)));
      check("gnt_snoop", 32'(gnt_snoop), 32'(exp_gs(m)));
      check("gnt_lv2", 32'(gnt_lv2), 32'(m.nest == 2));
      check("owner_id", 32'(owner), m.last);
      check("busy", 32'(busy), 32'(m.own >= 0));
      check("timeout", 32'(tmo), 32'(m.tmo));
      check("nest_excl", 32'((|gnt_snoop) & gnt_lv2), 32'(0));
      check("nest_under_proc",
            32'(((|gnt_snoop) | gnt_lv2) & ~(|gnt_proc)), 32'(0));
    end
  end

  task automatic do_reset();
    req_proc  = '0;
    req_snoop = '0;
    req_lv2   = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt_proc", 32'(gnt_proc), 32'(0));
    check("rst_gnt_snoop", 32'(gnt_snoop), 32'(0));
    check("rst_gnt_lv2", 32'(gnt_lv2), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_timeout", 32'(tmo), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses, at;
    req_proc  = '0;
    req_snoop = '0;
    req_lv2   = 1'b0;
    do_reset();
    chk_on = 1'b1;

    // S1: 0110 -> core1, release, idle gap, core2
    req_proc = 4'b0110;
    @(negedge clk);
    check("s1_grant1", 32'(gnt_proc), 32'(4'b0010));
    check("s1_model_pin", 32'(exp_gp(m)), 32'(4'b0010));
    @(negedge clk);
    @(negedge clk);
    req_proc = 4'b0100;
    @(negedge clk);
    check("s1_gap", 32'(gnt_proc), 32'(0));
    @(negedge clk);
    check("s1_grant2", 32'(gnt_proc), 32'(4'b0100));
    req_proc = '0;
    @(negedge clk);

    // S2: rotation 0,1,2,3,0 with one idle cycle between owners
    do_reset();
    req_proc = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int c;
      c = i % N;
      @(negedge clk);
      check("s2_rot", 32'(gnt_proc), 32'(N'(1) << c));
      check("s2_owner", 32'(owner), c);
      @(negedge clk);
      @(negedge clk);
      req_proc = req_proc & ~(N'(1) << c);
      @(negedge clk);
      check("s2_gap", 32'(gnt_proc), 32'(0));
      req_proc = req_proc | (N'(1) << c);
    end
    req_proc = '0;
    @(negedge clk);

    // S3: core0 owns, snoop 1011 -> 1 then 3, own snoop ignored
    do_reset();
    req_proc = 4'b0001;
    @(negedge clk);
    check("s3_owner", 32'(gnt_proc), 32'(4'b0001));
    req_snoop = 4'b1011;
    @(negedge clk);
    check("s3_snoop1", 32'(gnt_snoop), 32'(4'b0010));
    check("s3_proc_a", 32'(gnt_proc), 32'(4'b0001));
    @(negedge clk);
    req_snoop = 4'b1001;
    @(negedge clk);
    check("s3_proc_gap", 32'(gnt_snoop), 32'(0));
    check("s3_proc_b", 32'(gnt_proc), 32'(4'b0001));
    @(negedge clk);
    check("s3_snoop3", 32'(gnt_snoop), 32'(4'b1000));
    req_snoop = 4'b0001;
    @(negedge clk);
    check("s3_rel3", 32'(gnt_snoop), 32'(0));
    @(negedge clk);
    check("s3_own_ignored", 32'(gnt_snoop), 32'(0));
    check("s3_proc_c", 32'(gnt_proc), 32'(4'b0001));
    req_proc  = '0;
    req_snoop = '0;
    @(negedge clk);

    // S4: core2 owns, snoop and lv2 together -> snoop, gap, lv2
    do_reset();
    req_proc = 4'b0100;
    @(negedge clk);
    check("s4_owner", 32'(gnt_proc), 32'(4'b0100));
    req_snoop = 4'b0010;
    req_lv2   = 1'b1;
    @(negedge clk);
    check("s4_snoop_first", 32'(gnt_snoop), 32'(4'b0010));
    check("s4_lv2_waits", 32'(gnt_lv2), 32'(0));
    req_snoop = '0;
    @(negedge clk);
    check("s4_gap_lv2", 32'(gnt_lv2), 32'(0));
    check("s4_gap_snoop", 32'(gnt_snoop), 32'(0));
    @(negedge clk);
    check("s4_lv2", 32'(gnt_lv2), 32'(1));
    req_lv2 = 1'b0;
    @(negedge clk);
    check("s4_lv2_rel", 32'(gnt_lv2), 32'(0));
    req_proc = '0;
    @(negedge clk);

    // S5: core3 holds 20 cycles -> single timeout on grant cycle 8
    do_reset();
    req_proc = 4'b1000;
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tmo) begin
        pulses++;
        at = k;
      end
      if (k == 20) check("s5_held", 32'(gnt_proc), 32'(4'b1000));
    end
    check("s5_pulses", pulses, 32'(1));
    check("s5_when", at, 32'(MAXH));
    req_proc = '0;
    @(negedge clk);

    // S6: reset during LV2, then lowest-index requester first
    do_reset();
    req_proc = 4'b0001;
    @(negedge clk);
    check("s6_owner", 32'(gnt_proc), 32'(4'b0001));
    req_lv2 = 1'b1;
    @(negedge clk);
    check("s6_lv2", 32'(gnt_lv2), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_proc", 32'(gnt_proc), 32'(0));
    check("s6_async_lv2", 32'(gnt_lv2), 32'(0));
    check("s6_async_busy", 32'(busy), 32'(0));
    req_proc = 4'b1100;
    req_lv2  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_first_after_rst", 32'(gnt_proc), 32'(4'b0100));
    req_proc = '0;
    @(negedge clk);

    // Random traffic checked every cycle by the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0)
          req_proc = req_proc ^ (N'(1) << c);
        if ($urandom_range(0, 4) == 0)
          req_snoop = req_snoop ^ (N'(1) << c);
      end
      if ($urandom_range(0, 5) == 0) req_lv2 = ~req_lv2;
      if (cyc == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    req_proc  = '0;
    req_snoop = '0;
    req_lv2   = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
